dest_calc_stream: RTL and testbench

Parametrised destination-port extractor for the packet filter ingress path. Taps the ingress packet stream without back-pressuring it, gathers the destination MAC from the first beats of each frame, and emits one registered destination record per frame on a valid/ready channel toward the switch arbiter. Supersedes the fixed 3×16-bit calculator with packet framing, configurable port count, broadcast handling and output back-pressure with overflow reporting.

---
 rtl/filter_pkg.sv | 29 ++
 rtl/mac_shift_reg.sv | 47 ++++
 rtl/dest_calc_stream.sv | 156 +++++++++++++++
 tb/tb_dest_calc_stream.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the packet filter ingress path.
//   DEST_USER_INVALID / DEST_USER_BCAST : bit positions inside a destination record's user field
//   dest_calc_state_e                    : header/body tracking state of the destination extractor
//   dest_rec_t                           : destination record {port, user}, sized for the largest
//                                          supported port count so every instance can share it
//   port_width()                         : index width for a given port count (never below 1)
package filter_pkg;

    localparam int unsigned DEST_USER_INVALID = 0;
    localparam int unsigned DEST_USER_BCAST   = 1;

    localparam int unsigned DEST_MAX_PORTS  = 256;
    localparam int unsigned DEST_MAX_PORT_W = $clog2(DEST_MAX_PORTS);

    typedef enum logic [0:0] {
        HDR  = 1'b0,
        BODY = 1'b1
    } dest_calc_state_e;

    typedef struct packed {
        logic [DEST_MAX_PORT_W-1:0] port;
        logic [1:0]                 user;
    } dest_rec_t;

    function automatic int unsigned port_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mac_shift_reg.sv
// Destination-MAC gather register.
//   clk, reset_n : clock, asynchronous active-low reset (clears the register)
//   clear        : synchronous clear, wins over shift_en
//   shift_en     : shift din in as the newest (least significant) beat
//   din          : incoming beat
//   mac_full     : MAC as it stands once din is shifted in; valid as the complete MAC on the
//                  cycle the final header beat is presented, so a record can be formed without
//                  waiting a cycle for the register to update
module mac_shift_reg #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_BEATS = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W*NUM_BEATS-1:0] mac_full
);

    localparam int unsigned MAC_W = DATA_W * NUM_BEATS;

    if (NUM_BEATS > 1) begin : g_shift
        logic [MAC_W-1:0] mac_q;
        logic             unused_oldest_beat;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mac_q <= '0;
            end else if (clear) begin
                mac_q <= '0;
            end else if (shift_en) begin
                mac_q <= mac_full;
            end
        end

        assign mac_full = {mac_q[MAC_W-DATA_W-1:0], din};
        // The oldest beat is shifted out before it is ever needed.
        assign unused_oldest_beat = ^mac_q[MAC_W-1 -: DATA_W];
    end else begin : g_single
        logic unused_ctrl;

        assign mac_full    = din;
        assign unused_ctrl = ^{clk, reset_n, clear, shift_en};
    end

endmodule

// File: rtl/dest_calc_stream.sv
// Destination-port extractor: taps the ingress packet stream (no back-pressure), gathers the
// destination MAC from the first NUM_BEATS beats of each frame and emits one registered record
// per frame on a valid/ready channel.
//   clk, reset_n          : clock, asynchronous active-low reset
//   pkt_tvalid/tdata/tlast: observed ingress stream, MAC most-significant beat first
//   dest_tvalid/tready    : record handshake toward the switch arbiter
//   dest_tdata            : egress port index
//   dest_tuser            : bit0 invalid, bit1 broadcast
//   runt_err              : pulse, frame ended inside the header
//   ovf_err               : pulse, record dropped because the output register was still occupied
// Build option: define DEST_CALC_BCAST_EN to report an all-ones MAC as broadcast (port 0);
// otherwise it is reported invalid with the port taken from its low bits.
module dest_calc_stream
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAC_BITS  = 48,
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned PORT_W   = port_width(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pkt_tvalid,
    input  logic [DATA_W-1:0] pkt_tdata,
    input  logic              pkt_tlast,
    output logic              dest_tvalid,
    input  logic              dest_tready,
    output logic [PORT_W-1:0] dest_tdata,
    output logic [1:0]        dest_tuser,
    output logic              runt_err,
    output logic              ovf_err
);

    localparam int unsigned NUM_BEATS = MAC_BITS / DATA_W;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    dest_calc_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_en, mac_clear, rec_done, runt_d;
    logic             runt_q, ovf_q, ovf_d;
    logic             valid_q, valid_d;
    dest_rec_t        rec_q, rec_d, rec_new;
    logic [MAC_BITS-1:0] full_mac;
    logic [PORT_W-1:0]   port_raw;
    logic             unused_bits;

    mac_shift_reg #(
        .DATA_W    (DATA_W),
        .NUM_BEATS (NUM_BEATS)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (mac_clear),
        .shift_en (shift_en),
        .din      (pkt_tdata),
        .mac_full (full_mac)
    );

    // Header/body tracking; gaps (pkt_tvalid=0) leave everything frozen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        mac_clear = 1'b0;
        rec_done  = 1'b0;
        runt_d    = 1'b0;
        unique case (state_q)
            HDR: begin
                if (pkt_tvalid) begin
                    if (cnt_q == LAST_BEAT) begin
                        shift_en = 1'b1;
                        rec_done = 1'b1;
                        cnt_d    = '0;
                        // A header-only frame ends here and the next beat starts a new MAC.
                        state_d  = pkt_tlast ? HDR : BODY;
                    end else if (pkt_tlast) begin
                        runt_d    = 1'b1;
                        mac_clear = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        shift_en = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
            BODY: begin
                if (pkt_tvalid && pkt_tlast) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // Record decode from the MAC completed by the current beat.
    assign port_raw = full_mac[PORT_W-1:0];

    always_comb begin
        rec_new      = '0;
        rec_new.port = DEST_MAX_PORT_W'(port_raw);
        rec_new.user[DEST_USER_INVALID] = (full_mac[MAC_BITS-1 -: 2] == 2'b11) ||
                                          (32'(port_raw) >= NUM_PORTS);
`ifdef DEST_CALC_BCAST_EN
        if (&full_mac) begin
            rec_new.port                  = '0;
            rec_new.user                  = '0;
            rec_new.user[DEST_USER_BCAST] = 1'b1;
        end
`endif
    end

    // Single-entry output register; a new record never displaces an unaccepted one.
    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        ovf_d   = 1'b0;
        if (rec_done && (!valid_q || dest_tready)) begin
            valid_d = 1'b1;
            rec_d   = rec_new;
        end else if (rec_done) begin
            ovf_d = 1'b1;
        end else if (valid_q && dest_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HDR;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            rec_q   <= '0;
            runt_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rec_q   <= rec_d;
            runt_q  <= runt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dest_tvalid = valid_q;
    assign dest_tdata  = rec_q.port[PORT_W-1:0];
    assign dest_tuser  = rec_q.user;
    assign runt_err    = runt_q;
    assign ovf_err     = ovf_q;

    // Middle MAC bits matter only to the broadcast test; upper port bits are always zero here.
    assign unused_bits = ^{full_mac, rec_q.port};

endmodule

// File: tb/tb_dest_calc_stream.sv
// Self-checking bench for dest_calc_stream: a default 4-port instance (with output stalls) and a
// 3-port instance (always ready) watch the same stream; expected records are queued per instance
// as frames are driven and compared as each instance hands records over.
module tb_dest_calc_stream;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pkt_tvalid = 1'b0;
    logic [15:0] pkt_tdata = '0;
    logic        pkt_tlast = 1'b0;
    logic        dest_tready = 1'b1;
    logic        dest_tvalid;
    logic [1:0]  dest_tdata;
    logic [1:0]  dest_tuser;
    logic        runt_err;
    logic        ovf_err;
    logic        d3_tvalid;
    logic [1:0]  d3_tdata;
    logic [1:0]  d3_tuser;
    logic        d3_runt;
    logic        d3_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int runt_cnt = 0;
    int ovf_cnt = 0;
    int runt3_cnt = 0;
    int ovf3_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp3_q[$];
    logic       hold_active = 1'b0;
    logic [3:0] held = '0;

    always #5 clk = ~clk;

    dest_calc_stream u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pkt_tvalid  (pkt_tvalid),
        .pkt_tdata   (pkt_tdata),
        .pkt_tlast   (pkt_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tuser  (dest_tuser),
        .runt_err    (runt_err),
        .ovf_err     (ovf_err)
    );

    dest_calc_stream #(
        .NUM_PORTS (3)
    ) u_dut3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pkt_tvalid  (pkt_tvalid),
        .pkt_tdata   (pkt_tdata),
        .pkt_tlast   (pkt_tlast),
        .dest_tvalid (d3_tvalid),
        .dest_tready (1'b1),
        .dest_tdata  (d3_tdata),
        .dest_tuser  (d3_tuser),
        .runt_err    (d3_runt),
        .ovf_err     (d3_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode: {port[7:0], user[1:0]}.
    function automatic logic [9:0] model(input logic [47:0] mac, input int np);
        int   pw;
        int   port;
        logic inv;
        pw   = (np > 1) ? $clog2(np) : 1;
        port = int'(mac[15:0]) & ((1 << pw) - 1);
        inv  = (mac[47:46] == 2'b11) || (port >= np);
`ifdef DEST_CALC_BCAST_EN
        if (mac == 48'hFFFF_FFFF_FFFF) return {8'd0, 2'b10};
`endif
        return {8'(port), 1'b0, inv};
    endfunction

    task automatic push(input logic [47:0] mac, input bit to_main);
        if (to_main) exp_q.push_back(model(mac, 4));
        exp3_q.push_back(model(mac, 3));
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        @(posedge clk);
        #1;
        pkt_tvalid = 1'b1;
        pkt_tdata  = d;
        pkt_tlast  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pkt_tvalid = 1'b0;
            pkt_tlast  = 1'b0;
        end
    endtask

    task automatic frame3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b1);
        idle(1);
    endtask

    // Output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset_n) begin
            hold_active = 1'b0;
        end else begin
            if (runt_err) runt_cnt++;
            if (ovf_err) ovf_cnt++;
            if (d3_runt) runt3_cnt++;
            if (d3_ovf) ovf3_cnt++;
            if (dest_tvalid && dest_tready) begin
                if (exp_q.size() == 0) begin
                    check("main_unexpected_rec", 32'({dest_tdata, dest_tuser}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("main_port", 32'(dest_tdata), 32'(e[9:2]));
                    check("main_user", 32'(dest_tuser), 32'(e[1:0]));
                end
            end
            if (dest_tvalid && !dest_tready) begin
                if (hold_active) check("main_hold", 32'({dest_tdata, dest_tuser}), 32'(held));
                held        = {dest_tdata, dest_tuser};
                hold_active = 1'b1;
            end else begin
                hold_active = 1'b0;
            end
            if (d3_tvalid) begin
                if (exp3_q.size() == 0) begin
                    check("p3_unexpected_rec", 32'({d3_tdata, d3_tuser}), 32'hFFFF_FFFF);
                end else begin
                    e = exp3_q.pop_front();
                    check("p3_port", 32'(d3_tdata), 32'(e[9:2]));
                    check("p3_user", 32'(d3_tuser), 32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_valid", 32'(dest_tvalid), 32'd0);
        check("rst_tdata", 32'(dest_tdata), 32'd0);
        check("rst_tuser", 32'(dest_tuser), 32'd0);
        check("rst_runt", 32'(runt_err), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic frame with payload; record must appear one cycle after the third beat.
        push(48'h3A00_1111_0002, 1'b1);
        beat(16'h3A00, 1'b0);
        beat(16'h1111, 1'b0);
        @(negedge clk);
        check("lat_early", 32'(dest_tvalid), 32'd0);
        beat(16'h0002, 1'b0);
        beat(16'hAAAA, 1'b0);
        @(negedge clk);
        check("lat_one_cycle", 32'(dest_tvalid), 32'd1);
        beat(16'hBBBB, 1'b1);
        idle(3);

        // Locally-administered-style top bits -> invalid; gaps between beats.
        push(48'hC000_0000_0001, 1'b1);
        beat(16'hC000, 1'b0);
        idle(2);
        beat(16'h0000, 1'b0);
        idle(1);
        beat(16'h0001, 1'b1);
        idle(3);

        // Port 3: fine for 4 ports, out of range for 3 ports.
        push(48'h0000_0000_0003, 1'b1);
        frame3(16'h0000, 16'h0000, 16'h0003);
        idle(2);

        // All-ones MAC.
        push(48'hFFFF_FFFF_FFFF, 1'b1);
        frame3(16'hFFFF, 16'hFFFF, 16'hFFFF);
        idle(2);

        // Runt frame, then a good frame.
        beat(16'h1234, 1'b0);
        beat(16'h5678, 1'b1);
        idle(3);
        check("runt_pulse", 32'(runt_cnt), 32'd1);
        push(48'h0000_0000_0002, 1'b1);
        frame3(16'h0000, 16'h0000, 16'h0002);
        idle(2);

        // Output stalled over two frames: first kept, second dropped with one overflow.
        dest_tready = 1'b0;
        push(48'h0000_0000_0001, 1'b1);
        push(48'h0000_0000_0002, 1'b0);
        frame3(16'h0000, 16'h0000, 16'h0001);
        frame3(16'h0000, 16'h0000, 16'h0002);
        idle(3);
        check("ovf_once", 32'(ovf_cnt), 32'd1);
        check("stall_held_port", 32'(dest_tdata), 32'd1);
        @(posedge clk);
        #1;
        dest_tready = 1'b1;
        idle(3);

        // Reset mid-frame with a record pending: outputs clear at once.
        dest_tready = 1'b0;
        push(48'h0000_0000_0003, 1'b0);
        frame3(16'h0000, 16'h0000, 16'h0003);
        idle(2);
        check("pre_reset_valid", 32'(dest_tvalid), 32'd1);
        beat(16'hAAAA, 1'b0);
        beat(16'hBBBB, 1'b0);
        @(posedge clk);
        #1;
        pkt_tvalid = 1'b0;
        reset_n    = 1'b0;
        #1;
        check("reset_valid", 32'(dest_tvalid), 32'd0);
        check("reset_tdata", 32'(dest_tdata), 32'd0);
        check("reset_tuser", 32'(dest_tuser), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n     = 1'b1;
        dest_tready = 1'b1;
        push(48'h1234_5678_0001, 1'b1);
        frame3(16'h1234, 16'h5678, 16'h0001);
        idle(4);

        check("main_queue_drained", 32'(exp_q.size()), 32'd0);
        check("p3_queue_drained", 32'(exp3_q.size()), 32'd0);
        check("runt_total", 32'(runt_cnt), 32'd1);
        check("p3_runt_total", 32'(runt3_cnt), 32'd1);
        check("ovf_total", 32'(ovf_cnt), 32'd1);
        check("p3_ovf_total", 32'(ovf3_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
